hazard_scoreboard: RTL

Tracks destination registers of instructions in flight in the EXE, MEM and WB stages. It sits beside the ID stage and compares the ID instruction's source registers against the in-flight writers. From that comparison it produces the pipeline stall (`hazard`) and, when compiled in, the EXE-stage forwarding selects. Its slot pipeline shadows the ID→EXE→MEM→WB registers exactly, including freezes and flushes.

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer scoreboard producing ID stall and EXE forwarding selects
//
// Purpose: shadows the ID->EXE->MEM->WB pipeline registers with three slots
// (EXE, MEM, WB) holding each in-flight instruction's writeback and source
// information. The ID instruction's sources are compared against those slots
// to raise the pipeline stall, and the EXE slot's sources are compared against
// MEM/WB to produce operand forwarding selects.
//
// Build option: FORWARDING_EN
//   defined   - stall only on load-use against EXE; fwd_sel_a/fwd_sel_b active.
//   undefined - full RAW stall against EXE and MEM; fwd_sel_a/fwd_sel_b tied 0.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   id_valid                  ID holds a real instruction
//   src1/src2, use_src1/2     ID source registers and their read enables
//   id_wb_en, id_dest         ID writeback enable and destination
//   id_mem_r                  ID instruction is a load
//   mem_freeze                whole pipeline holds this cycle
//   flush                     branch taken in EXE, ID squashed this cycle
//   hazard                    combinational stall request for IF/ID
//   fwd_sel_a/fwd_sel_b       EXE operand source: 0 reg file, 1 MEM, 2 WB
//   stall_count               saturating count of stall cycles

module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             use_src2,
  input  logic             id_wb_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_mem_r,
  input  logic             mem_freeze,
  input  logic             flush,
  output logic             hazard,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_count
);

  // Register 15 is the PC; writes to it are never tracked as hazards.
  localparam logic [REG_W-1:0] PC_REG = REG_W'(15);

  typedef struct packed {
    logic             v;
    logic             wb_en;
    logic             mem_r;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             use1;
    logic             use2;
  } slot_t;

  slot_t            exe_q, mem_q, wb_q;
  slot_t            exe_d, mem_d, wb_d;
  slot_t            id_slot;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  function automatic logic match(input slot_t s, input logic [REG_W-1:0] r);
    return s.v & s.wb_en & (s.dest == r) & (r != PC_REG);
  endfunction

  always_comb begin
    id_slot       = '0;
    id_slot.v     = id_valid;
    id_slot.wb_en = id_wb_en;
    id_slot.mem_r = id_mem_r;
    id_slot.dest  = id_dest;
    id_slot.src1  = src1;
    id_slot.src2  = src2;
    id_slot.use1  = use_src1;
    id_slot.use2  = use_src2;
  end

`ifdef FORWARDING_EN
  // ALU results forward from MEM/WB, so only a load still in EXE blocks ID.
  assign hazard = id_valid & ~flush & exe_q.mem_r &
                  ((use_src1 & match(exe_q, src1)) |
                   (use_src2 & match(exe_q, src2)));

  // MEM is the younger writer, so it wins over WB.
  always_comb begin
    fwd_sel_a = 2'd0;
    fwd_sel_b = 2'd0;
    if (exe_q.use1 & match(mem_q, exe_q.src1))     fwd_sel_a = 2'd1;
    else if (exe_q.use1 & match(wb_q, exe_q.src1)) fwd_sel_a = 2'd2;
    if (exe_q.use2 & match(mem_q, exe_q.src2))     fwd_sel_b = 2'd1;
    else if (exe_q.use2 & match(wb_q, exe_q.src2)) fwd_sel_b = 2'd2;
  end
`else
  // WB is excluded: the register file writes on the falling edge, so the
  // same-cycle ID read already sees the WB value.
  assign hazard = id_valid & ~flush &
                  ((use_src1 & (match(exe_q, src1) | match(mem_q, src1))) |
                   (use_src2 & (match(exe_q, src2) | match(mem_q, src2))));

  assign fwd_sel_a = 2'd0;
  assign fwd_sel_b = 2'd0;
`endif

  // Slot fields that one build or the other never reads.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{exe_q, mem_q, wb_q};

  always_comb begin
    exe_d         = exe_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    if (!mem_freeze) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      exe_d = (id_valid & ~hazard & ~flush) ? id_slot : '0;
      if (hazard && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q         <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      exe_q         <= exe_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
